acc_unit: RTL and testbench

Parametrised multi-channel accumulator execution unit, the next generation of the 16-bit accumulator datapath. It holds NUM_ACC = 2**SEL_W independent WIDTH-bit accumulators. Operations arrive over a valid/ready handshake, and each accepted operation returns one registered result with flags. It supports single-cycle ALU operations and a multi-cycle shift-add multiply. The unit sits between the instruction decode/control logic and the I/O output path of the accumulator processor.

---
 rtl/acc_unit.sv | 193 +++++++++++++++++++
 tb/tb_acc_unit.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/acc_unit.sv
// Multi-channel accumulator execution unit: single-cycle ALU ops plus a WIDTH-step shift-add multiply.
// Optional macro ACC_SAT_EN makes ADD/SUB saturate on signed overflow instead of wrapping.
module acc_unit #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 2
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [3:0]       op_code,
  input  logic [SEL_W-1:0] op_sel,
  input  logic [WIDTH-1:0] op_data,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_zero,
  output logic             res_neg,
  output logic             res_ovf,
  output logic             res_err,
  output logic             dbg_state_o
);

  localparam int NUM_ACC = 2 ** SEL_W;
  localparam int CNT_W   = $clog2(WIDTH + 1);
  localparam int HALF    = WIDTH / 2;
  localparam int MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_SLT  = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_MUL  = 4'd8;
  localparam logic [3:0] OP_CLR  = 4'd10;

  typedef enum logic {S_IDLE = 1'b0, S_MUL_RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q [NUM_ACC];
  logic [WIDTH-1:0]   acc_d [NUM_ACC];
  logic [WIDTH-1:0]   mcand_q, mcand_d, mplier_q, mplier_d, prod_q, prod_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic               res_valid_q, res_valid_d, res_zero_q, res_zero_d, res_neg_q, res_neg_d;
  logic               res_ovf_q, res_ovf_d, res_err_q, res_err_d;
  logic [WIDTH-1:0]   res_data_q, res_data_d;

  logic [WIDTH-1:0]   acc_a, sum, diff, sat_val, alu_res, step_prod;
  logic               add_ovf, sub_ovf, alu_ovf, alu_err;

  // Single-cycle ALU result for the accumulator addressed by the incoming request.
  always_comb begin
    acc_a   = acc_q[op_sel];
    sum     = acc_a + op_data;
    diff    = acc_a - op_data;
    add_ovf = (acc_a[MSB] == op_data[MSB]) && (sum[MSB] != acc_a[MSB]);
    sub_ovf = (acc_a[MSB] != op_data[MSB]) && (diff[MSB] != acc_a[MSB]);
    sat_val = acc_a[MSB] ? SMIN : SMAX;
    alu_res = acc_a;
    alu_ovf = 1'b0;
    alu_err = 1'b0;
    case (op_code)
      4'd0, 4'd9, OP_MUL: alu_res = acc_a;
      OP_LOAD: alu_res = op_data;
      OP_ADD: begin
        alu_ovf = add_ovf;
`ifdef ACC_SAT_EN
        alu_res = add_ovf ? sat_val : sum;
`else
        alu_res = sum;
`endif
      end
      OP_SUB: begin
        alu_ovf = sub_ovf;
`ifdef ACC_SAT_EN
        alu_res = sub_ovf ? sat_val : diff;
`else
        alu_res = diff;
`endif
      end
      OP_AND:  alu_res = acc_a & op_data;
      OP_OR:   alu_res = acc_a | op_data;
      OP_SLT:  alu_res = ($signed(acc_a) < $signed(op_data)) ? WIDTH'(1) : '0;
      OP_LUI:  alu_res = {op_data[HALF-1:0], {HALF{1'b0}}};
      OP_CLR:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    sel_d       = sel_q;
    res_valid_d = 1'b0;
    res_data_d  = res_data_q;
    res_zero_d  = res_zero_q;
    res_neg_d   = res_neg_q;
    res_ovf_d   = res_ovf_q;
    res_err_d   = res_err_q;
    step_prod   = prod_q + (mplier_q[0] ? mcand_q : '0);
    case (state_q)
      S_IDLE: begin
        if (op_valid) begin
          if (op_code == OP_MUL) begin
            state_d  = S_MUL_RUN;
            mcand_d  = acc_a;
            mplier_d = op_data;
            prod_d   = '0;
            cnt_d    = CNT_W'(WIDTH);
            sel_d    = op_sel;
          end else begin
            acc_d[op_sel] = alu_res;
            res_valid_d   = 1'b1;
            res_data_d    = alu_res;
            res_ovf_d     = alu_ovf;
            res_err_d     = alu_err;
          end
        end
      end
      S_MUL_RUN: begin
        // The last step writes the accumulator with the step's sum directly.
        prod_d   = step_prod;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d      = S_IDLE;
          acc_d[sel_q] = step_prod;
          res_valid_d  = 1'b1;
          res_data_d   = step_prod;
          res_ovf_d    = 1'b0;
          res_err_d    = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (res_valid_d) begin
      res_zero_d = (res_data_d == '0);
      res_neg_d  = res_data_d[MSB];
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      for (int i = 0; i < NUM_ACC; i++) acc_q[i] <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      sel_q       <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_zero_q  <= 1'b0;
      res_neg_q   <= 1'b0;
      res_ovf_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      sel_q       <= sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_zero_q  <= res_zero_d;
      res_neg_q   <= res_neg_d;
      res_ovf_q   <= res_ovf_d;
      res_err_q   <= res_err_d;
    end
  end

  // Handshake: a request transfers on a rising edge where op_valid && op_ready; op_ready is high only in IDLE.
  assign op_ready    = (state_q == S_IDLE);
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_zero    = res_zero_q;
  assign res_neg     = res_neg_q;
  assign res_ovf     = res_ovf_q;
  assign res_err     = res_err_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_acc_unit.sv
// Directed bench for acc_unit: arithmetic reference model, result scoreboard and literal pin checks.
module tb_acc_unit;
  localparam int W = 16;

  logic         CLK = 1'b0;
  logic         reset;
  logic         op_valid;
  logic         op_ready;
  logic [3:0]   op_code;
  logic [1:0]   op_sel;
  logic [W-1:0] op_data;
  logic         res_valid;
  logic [W-1:0] res_data;
  logic         res_zero, res_neg, res_ovf, res_err;
  logic         dbg_state;

  acc_unit #(.WIDTH(W), .SEL_W(2)) dut (
    .CLK(CLK), .reset(reset), .op_valid(op_valid), .op_ready(op_ready),
    .op_code(op_code), .op_sel(op_sel), .op_data(op_data),
    .res_valid(res_valid), .res_data(res_data), .res_zero(res_zero),
    .res_neg(res_neg), .res_ovf(res_ovf), .res_err(res_err),
    .dbg_state_o(dbg_state)
  );

  // Clock / reset
  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int pulses = 0;

  logic [W-1:0] exp_q[$];
  logic [1:0]   exp_f_q[$];
  int           exp_t_q[$];
  int           exp_lat_q[$];
  logic [W-1:0] model_acc [4];
  logic [W-1:0] hist_q[$];
  int           hist_cyc_q[$];
  logic [W-1:0] last_data;
  logic         last_zero, last_neg, last_ovf, last_err;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: {err, ovf, value} from the operation rules, with plain integer arithmetic.
  function automatic logic [W+1:0] model_op(input logic [3:0] code, input logic [W-1:0] a,
                                            input logic [W-1:0] d);
    int          s;
    logic [31:0] p;
    logic [W-1:0] v;
    logic        ovf, err;
    v = a; ovf = 1'b0; err = 1'b0;
    case (code)
      4'd1: v = d;
      4'd2, 4'd3: begin
        s = (code == 4'd2) ? int'($signed(a)) + int'($signed(d)) : int'($signed(a)) - int'($signed(d));
        v = W'(s);
        ovf = (s > 32767) || (s < -32768);
`ifdef ACC_SAT_EN
        if (ovf) v = (s > 0) ? 16'h7FFF : 16'h8000;
`endif
      end
      4'd4: v = a & d;
      4'd5: v = a | d;
      4'd6: v = ($signed(a) < $signed(d)) ? 16'd1 : 16'd0;
      4'd7: v = {d[7:0], 8'h00};
      4'd8: begin p = a * d; v = p[15:0]; end
      4'd10: v = '0;
      4'd11, 4'd12, 4'd13, 4'd14, 4'd15: err = 1'b1;
      default: v = a;
    endcase
    return {err, ovf, v};
  endfunction

  // Scoreboard compare: every result pulse is matched against the oldest expected result.
  always @(negedge CLK) begin
    logic [W-1:0] ev;
    logic [1:0]   ef;
    int           et, el;
    cyc++;
    if (res_valid === 1'b1) begin
      pulses++;
      last_data = res_data; last_zero = res_zero; last_neg = res_neg;
      last_ovf = res_ovf; last_err = res_err;
      hist_q.push_back(res_data);
      hist_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_res: got pulse with data 0x%0h, expected no pulse (t=%0t)", res_data, $time);
      end else begin
        ev = exp_q.pop_front();
        ef = exp_f_q.pop_front();
        et = exp_t_q.pop_front();
        el = exp_lat_q.pop_front();
        check("res_data", res_data, ev);
        check("res_zero", res_zero, ev == '0);
        check("res_neg", res_neg, ev[W-1]);
        check("res_ovf", res_ovf, ef[0]);
        check("res_err", res_err, ef[1]);
        check("latency", cyc - et, el);
      end
    end
  end

  // Driver tasks
  task automatic issue(input logic [3:0] code, input logic [1:0] sel, input logic [W-1:0] d);
    int waited = 0;
    logic [W+1:0] r;
    @(negedge CLK);
    op_valid = 1'b1; op_code = code; op_sel = sel; op_data = d;
    while (!op_ready && waited < 40) begin
      @(negedge CLK);
      waited++;
    end
    if (!op_ready) begin
      check("accept_timeout", op_ready, 1'b1);
      op_valid = 1'b0;
      return;
    end
    @(posedge CLK);
    r = model_op(code, model_acc[sel], d);
    if (code != 4'd8 || 1'b1) model_acc[sel] = r[W-1:0];
    exp_q.push_back(r[W-1:0]);
    exp_f_q.push_back(r[W+1:W]);
    exp_t_q.push_back(cyc);
    exp_lat_q.push_back((code == 4'd8) ? W + 1 : 1);
  endtask

  task automatic drain();
    int n = 0;
    @(negedge CLK);
    op_valid = 1'b0;
    #1;
    while (exp_q.size() != 0 && n < 40) begin
      @(negedge CLK);
      #1;
      n++;
    end
    check("drain_pending", exp_q.size(), 0);
    exp_q.delete(); exp_f_q.delete(); exp_t_q.delete(); exp_lat_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int p0;
    reset = 1'b0; op_valid = 1'b0; op_code = '0; op_sel = '0; op_data = '0;
    for (int i = 0; i < 4; i++) model_acc[i] = '0;
    repeat (2) @(negedge CLK);
    check("rst_op_ready", op_ready, 1'b1);
    check("rst_res_valid", res_valid, 1'b0);
    check("rst_res_data", res_data, 16'h0000);
    check("rst_res_zero", res_zero, 1'b0);
    check("rst_res_neg", res_neg, 1'b0);
    check("rst_res_ovf", res_ovf, 1'b0);
    check("rst_res_err", res_err, 1'b0);
    reset = 1'b1;

    // Abort a multiply with reset at step 5
    issue(4'd1, 2'd0, 16'h0003);
    issue(4'd8, 2'd0, 16'h0007);
    @(negedge CLK);
    op_valid = 1'b0;
    repeat (5) @(negedge CLK);
    reset = 1'b0;
    exp_q.delete(); exp_f_q.delete(); exp_t_q.delete(); exp_lat_q.delete();
    for (int i = 0; i < 4; i++) model_acc[i] = '0;
    p0 = pulses;
    repeat (3) @(negedge CLK);
    reset = 1'b1;
    repeat (20) @(negedge CLK);
    check("abort_no_pulse", pulses - p0, 0);
    for (int i = 0; i < 4; i++) begin
      issue(4'd9, 2'(i), 16'h0000);
      drain();
      check("post_rst_read", last_data, 16'h0000);
      check("post_rst_zero", last_zero, 1'b1);
    end

    // Independent channels, ADD/SUB
    issue(4'd1, 2'd1, 16'h0014);
    issue(4'd2, 2'd1, 16'h000A);
    drain();
    check("add_ch1", last_data, 16'h001E);
    issue(4'd3, 2'd1, 16'h0028);
    drain();
    check("sub_ch1", last_data, 16'hFFF6);
    check("sub_ch1_neg", last_neg, 1'b1);
    issue(4'd9, 2'd0, 16'h0000);
    drain();
    check("read_ch0", last_data, 16'h0000);

    // SLT, LUI, illegal opcode
    issue(4'd1, 2'd2, 16'h0014);
    issue(4'd6, 2'd2, 16'h000A);
    drain();
    check("slt_first", last_data, 16'h0000);
    issue(4'd6, 2'd2, 16'h000A);
    drain();
    check("slt_second", last_data, 16'h0001);
    issue(4'd7, 2'd2, 16'h0008);
    drain();
    check("lui", last_data, 16'h0800);
    issue(4'd13, 2'd2, 16'h1234);
    drain();
    check("illegal_value", last_data, 16'h0800);
    check("illegal_err", last_err, 1'b1);

    // Multiply timing with a stray request during the busy window
    issue(4'd1, 2'd3, 16'h0014);
    drain();
    issue(4'd8, 2'd3, 16'h000A);
    @(negedge CLK);
    op_valid = 1'b1; op_code = 4'd1; op_sel = 2'd0; op_data = 16'hBEEF;
    check("mul_busy", op_ready, 1'b0);
    for (int k = 2; k <= W; k++) begin
      @(negedge CLK);
      if (k == 12) op_valid = 1'b0;
      check("mul_busy", op_ready, 1'b0);
    end
    @(negedge CLK);
    #1;
    check("mul_ready_back", op_ready, 1'b1);
    check("mul_result", last_data, 16'h00C8);
    drain();
    issue(4'd9, 2'd0, 16'h0000);
    drain();
    check("stray_ignored", last_data, 16'h0000);
    issue(4'd1, 2'd1, 16'h1234);
    issue(4'd8, 2'd1, 16'h5678);
    drain();

    // Signed overflow on ADD and SUB
    issue(4'd1, 2'd0, 16'h7FFF);
    issue(4'd2, 2'd0, 16'h0001);
    drain();
`ifdef ACC_SAT_EN
    check("add_ovf_val", last_data, 16'h7FFF);
`else
    check("add_ovf_val", last_data, 16'h8000);
`endif
    check("add_ovf_flag", last_ovf, 1'b1);
    issue(4'd1, 2'd0, 16'h8000);
    issue(4'd3, 2'd0, 16'h0001);
    drain();
`ifdef ACC_SAT_EN
    check("sub_ovf_val", last_data, 16'h8000);
`else
    check("sub_ovf_val", last_data, 16'h7FFF);
`endif
    check("sub_ovf_flag", last_ovf, 1'b1);

    // Back-to-back stream on ch0
    hist_q.delete(); hist_cyc_q.delete();
    issue(4'd1, 2'd0, 16'h0005);
    issue(4'd2, 2'd0, 16'h0003);
    issue(4'd4, 2'd0, 16'h0006);
    issue(4'd5, 2'd0, 16'h0001);
    drain();
    check("stream_count", hist_q.size(), 4);
    if (hist_q.size() == 4) begin
      check("stream_0", hist_q[0], 16'h0005);
      check("stream_1", hist_q[1], 16'h0008);
      check("stream_2", hist_q[2], 16'h0000);
      check("stream_3", hist_q[3], 16'h0001);
      check("stream_span", hist_cyc_q[3] - hist_cyc_q[0], 3);
    end

    // CLR
    issue(4'd10, 2'd1, 16'hFFFF);
    drain();
    check("clr", last_data, 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
